// File: rtl/stack_ptr_seq_if.sv
// Request/response handshake bundle for the stack-pointer sequencer.
interface stack_ptr_seq_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_addr;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_err
    );
endinterface

// File: rtl/stack_ptr_seq.sv
// Stack-pointer sequencer: reads SP from the register file, applies PUSH/POP/PEEK/SETSP
// with overflow/underflow checks, writes SP back and returns the memory address.
module stack_ptr_seq #(
    parameter logic [15:0] STEP   = 16'd2,
    parameter logic [15:0] SP_TOP = 16'h7fcd
) (
    input  logic                  clk,
    input  logic                  reset,
    stack_ptr_seq_if.slave        bus,
    output logic [1:0]            rf_address,
    output logic                  rf_regWrite,
    output logic [15:0]           rf_w_data,
    input  logic [15:0]           rf_r_data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RDSP = 2'd1;
    localparam logic [1:0] WB   = 2'd2;
    localparam logic [1:0] RSP  = 2'd3;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;
    localparam logic [1:0] OP_SETSP = 2'b11;

    localparam logic [1:0] RF_SP   = 2'd1;
    localparam logic [1:0] RF_NONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rsp_addr_q, rsp_addr_d;
    logic        rsp_err_q, rsp_err_d;

    logic [15:0] sp;
    logic [15:0] sp_next;
    logic [15:0] op_addr;
    logic        op_err;
    logic        op_wr;

    // Operation result, only meaningful while in WB.
    always_comb begin
        sp      = (op_q == OP_SETSP) ? data_q : rf_r_data;
        sp_next = sp;
        op_addr = sp;
        op_err  = 1'b0;
        op_wr   = 1'b0;
        case (op_q)
            OP_PUSH: begin
                if (sp < STEP) begin
                    op_err = 1'b1;
                end else begin
                    sp_next = sp - STEP;
                    op_addr = sp - STEP;
                    op_wr   = 1'b1;
                end
            end
            OP_POP: begin
                if (sp > (SP_TOP - STEP)) begin
                    op_err = 1'b1;
                end else begin
                    sp_next = sp + STEP;
                    op_wr   = 1'b1;
                end
            end
            OP_PEEK:  op_wr = 1'b0;
            default:  op_wr = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        rsp_addr_d = rsp_addr_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    data_d  = bus.req_data;
                    state_d = (bus.req_op == OP_SETSP) ? WB : RDSP;
                end
            end
            RDSP: state_d = WB;
            WB: begin
                rsp_addr_d = op_addr;
                rsp_err_d  = op_err;
                state_d    = RSP;
            end
            default: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_PUSH;
            data_q     <= '0;
            rsp_addr_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Outputs are masked while reset is high so an aborted WB cannot reach the register file.
    always_comb begin
        bus.req_ready = !reset && (state_q == IDLE);
        bus.rsp_valid = !reset && (state_q == RSP);
        bus.rsp_addr  = rsp_addr_q;
        bus.rsp_err   = rsp_err_q;
        rf_address    = (!reset && (state_q == RDSP || state_q == WB)) ? RF_SP : RF_NONE;
        rf_regWrite   = !reset && (state_q == WB) && op_wr;
        rf_w_data     = rf_regWrite ? sp_next : '0;
    end
endmodule
